// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter slice.
//   arb_owner_t        : which requester drives the memory port this cycle
//   starve_cnt_width() : bit width of the starvation counter for a given limit
//   DEF_*              : default parameter values for dmem_arbiter
// No ports (package).
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int DEF_STARVE_MAX = 4;
    localparam int DEF_AW         = 32;
    localparam int DEF_DW         = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } arb_owner_t;

    // Counter must be able to hold the value STARVE_MAX itself.
    function automatic int starve_cnt_width(input int starve_max);
        return $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_perf.sv
// ----------------------------------------------------------------------------
// dmem_arb_perf
// Performance counters for the arbiter; only instantiated when the top is
// built with DMEM_ARB_PERF_EN. All counters wrap at 2^32.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   owner_i           : port owner this cycle
//   stall_i           : core stall strobe this cycle
//   perf_core_cnt_o   : number of cycles the core was granted
//   perf_dma_cnt_o    : number of DMA grants
//   perf_stall_cnt_o  : number of core stall cycles
// ----------------------------------------------------------------------------
module dmem_arb_perf
    import dmem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  arb_owner_t  owner_i,
    input  logic        stall_i,
    output logic [31:0] perf_core_cnt_o,
    output logic [31:0] perf_dma_cnt_o,
    output logic [31:0] perf_stall_cnt_o
);

    logic [31:0] core_cnt_q,  core_cnt_d;
    logic [31:0] dma_cnt_q,   dma_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        core_cnt_d  = core_cnt_q  + {31'd0, (owner_i == OWN_CORE)};
        dma_cnt_d   = dma_cnt_q   + {31'd0, (owner_i == OWN_DMA)};
        stall_cnt_d = stall_cnt_q + {31'd0, stall_i};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_cnt_q  <= '0;
            dma_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            core_cnt_q  <= core_cnt_d;
            dma_cnt_q   <= dma_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_core_cnt_o  = core_cnt_q;
    assign perf_dma_cnt_o   = dma_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the ARM core data interface and
// a DMA/loader. The core wins by fixed priority; a starvation counter forces
// a DMA grant after STARVE_MAX consecutive lost contested cycles, stalling
// the core for that one cycle.
// Optional feature: define DMEM_ARB_PERF_EN to add perf_core_cnt,
// perf_dma_cnt and perf_stall_cnt (32-bit wrapping event counters).
// Ports:
//   clk, reset                          : clock, async active-high reset
//   core_req/we/addr/wdata, core_rdata  : core access, same-cycle load data
//   core_stall                          : core must re-present its access
//   dma_req/we/addr/wdata, dma_gnt      : DMA request, accepted at this edge
//   dma_rvalid, dma_rdata               : registered DMA read response
//   mem_we/addr/wdata, mem_rdata        : memory port (combinational read)
// ----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_core_cnt,
    output logic [31:0]   perf_dma_cnt,
    output logic [31:0]   perf_stall_cnt
`endif
);

    localparam int            CW         = starve_cnt_width(STARVE_MAX);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_owner_t    owner;
    logic [CW-1:0] starve_q,   starve_d;
    logic          rvalid_q,   rvalid_d;
    logic [DW-1:0] rdata_q,    rdata_d;

    // Owner select: core by priority, DMA only when uncontested or starved.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        owner = OWN_NONE;
        if (core_req && dma_req) begin
            owner = (starve_q == STARVE_LIM) ? OWN_DMA : OWN_CORE;
        end else if (core_req) begin
            owner = OWN_CORE;
        end else if (dma_req) begin
            owner = OWN_DMA;
        end
    end

    // Memory port mux and handshake strobes.
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        dma_gnt    = 1'b0;
        core_stall = 1'b0;
        core_rdata = mem_rdata;
        unique case (owner)
            OWN_CORE: mem_we = core_we;
            OWN_DMA: begin
                mem_we     = dma_we;
                mem_addr   = dma_addr;
                mem_wdata  = dma_wdata;
                dma_gnt    = 1'b1;
                core_stall = core_req;
            end
            default: ;
        endcase
        // Strobes are gated during reset so no partial write or grant escapes.
        if (reset) begin
            mem_we     = 1'b0;
            dma_gnt    = 1'b0;
            core_stall = 1'b0;
        end
    end

    // Starvation counter and DMA read-response next state.
    always_comb begin
        if (!dma_req || owner == OWN_DMA) begin
            starve_d = '0;
        end else if (starve_q == STARVE_LIM) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + 1'b1;
        end
        rvalid_d = (owner == OWN_DMA) && !dma_we;
        rdata_d  = rvalid_d ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            starve_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = rdata_q;

`ifdef DMEM_ARB_PERF_EN
    dmem_arb_perf u_perf (
        .clk              (clk),
        .reset            (reset),
        .owner_i          (owner),
        .stall_i          (core_stall),
        .perf_core_cnt_o  (perf_core_cnt),
        .perf_dma_cnt_o   (perf_dma_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter (STARVE_MAX=4, AW=DW=32). A 256-word
// memory sits on the mem_* port; a separate reference memory and a
// cycle-level model of the arbitration rules predict every output.
// Define DMEM_ARB_PERF_EN to also check the performance counters.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, dma_req, dma_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        core_stall, dma_gnt, dma_rvalid;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_core_cnt, perf_dma_cnt, perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem       [256];
    logic [31:0] model_mem [256];
    logic        mem_init;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_MAX(SM), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_core_cnt  (perf_core_cnt),
        .perf_dma_cnt   (perf_dma_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Word-addressed memory model on the port, combinational read.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = '0; dma_wdata  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_init = 1'b1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h40; core_wdata = 32'h1234;
        dma_req  = 1'b1; dma_we  = 1'b1; dma_addr  = 32'h44; dma_wdata  = 32'h5678;
        for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
        @(negedge clk);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0b exp=0", mem_we); end
        checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL reset_dma_gnt got=%0b exp=0", dma_gnt); end
        checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL reset_core_stall got=%0b exp=0", core_stall); end
        checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL reset_dma_rvalid got=%0b exp=0", dma_rvalid); end
        checks++; if (dma_rdata !== 32'h0) begin failures++; $display("FAIL reset_dma_rdata got=%h exp=0", dma_rdata); end
        tick();
        mem_init = 1'b0;
        reset = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_core_store();
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'd100; core_wdata = 32'd7;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL core_store_we got=%0b exp=1", mem_we); end
        checks++; if (mem_addr !== 32'd100) begin failures++; $display("FAIL core_store_addr got=%0d exp=100", mem_addr); end
        checks++; if (mem_wdata !== 32'd7) begin failures++; $display("FAIL core_store_wdata got=%0d exp=7", mem_wdata); end
        checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL core_store_stall got=%0b exp=0", core_stall); end
        checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL core_store_gnt got=%0b exp=0", dma_gnt); end
        tick();
        model_mem[25] = 32'd7;
        idle();
    endtask

    task automatic test_dma_read();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h64;
        @(negedge clk);
        checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL dma_read_gnt got=%0b exp=1", dma_gnt); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL dma_read_we got=%0b exp=0", mem_we); end
        checks++; if (mem_addr !== 32'h64) begin failures++; $display("FAIL dma_read_addr got=%h exp=64", mem_addr); end
        tick();
        idle();
        @(negedge clk);
        checks++; if (dma_rvalid !== 1'b1) begin failures++; $display("FAIL dma_read_rvalid got=%0b exp=1", dma_rvalid); end
        checks++; if (dma_rdata !== 32'd7) begin failures++; $display("FAIL dma_read_rdata got=%0d exp=7", dma_rdata); end
        tick();
        @(negedge clk);
        checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL dma_read_rvalid_drop got=%0b exp=0", dma_rvalid); end
        tick();
    endtask

    // Both requesters active for 10 cycles: DMA forced on the 5th and 10th.
    task automatic test_starvation();
        bit exp_dma;
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h20;
        dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 32'h24;
        for (int i = 0; i < 10; i++) begin
            exp_dma = (i == SM) || (i == 2 * SM + 1);
            @(negedge clk);
            checks++; if (dma_gnt !== exp_dma) begin failures++; $display("FAIL starve_gnt cyc=%0d got=%0b exp=%0b", i, dma_gnt, exp_dma); end
            checks++; if (core_stall !== exp_dma) begin failures++; $display("FAIL starve_stall cyc=%0d got=%0b exp=%0b", i, core_stall, exp_dma); end
            checks++; if (mem_addr !== (exp_dma ? 32'h24 : 32'h20)) begin failures++; $display("FAIL starve_addr cyc=%0d got=%h", i, mem_addr); end
            checks++; if (dma_rvalid !== (i == SM + 1)) begin failures++; $display("FAIL starve_rvalid cyc=%0d got=%0b exp=%0b", i, dma_rvalid, (i == SM + 1)); end
            if (i == SM + 1) begin
                checks++; if (dma_rdata !== model_mem[9]) begin failures++; $display("FAIL starve_rdata got=%h exp=%h", dma_rdata, model_mem[9]); end
            end
            tick();
        end
`ifdef DMEM_ARB_PERF_EN
        checks++; if (perf_core_cnt !== 32'd8) begin failures++; $display("FAIL perf_core got=%0d exp=8", perf_core_cnt); end
        checks++; if (perf_dma_cnt !== 32'd2) begin failures++; $display("FAIL perf_dma got=%0d exp=2", perf_dma_cnt); end
        checks++; if (perf_stall_cnt !== 32'd2) begin failures++; $display("FAIL perf_stall got=%0d exp=2", perf_stall_cnt); end
`endif
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        for (int k = 0; k < 3; k++) vals[k] = $urandom;
        for (int k = 0; k < 3; k++) begin
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h10 + 32'(4 * k); dma_wdata = vals[k];
            @(negedge clk);
            checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt k=%0d got=%0b exp=1", k, dma_gnt); end
            checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL b2b_we k=%0d got=%0b exp=1", k, mem_we); end
            tick();
            model_mem[4 + k] = vals[k];
        end
        idle();
        tick();
        @(negedge clk);
        checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_no_rvalid got=%0b exp=0", dma_rvalid); end
        for (int k = 0; k < 3; k++) begin
            core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10 + 32'(4 * k);
            @(negedge clk);
            checks++; if (core_rdata !== vals[k]) begin failures++; $display("FAIL b2b_readback k=%0d got=%h exp=%h", k, core_rdata, vals[k]); end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
        @(negedge clk);
        checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL rmid_gnt got=%0b exp=1", dma_gnt); end
        tick();
        reset = 1'b1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hDEAD_BEEF;
        dma_req  = 1'b1; dma_we  = 1'b1; dma_addr  = 32'h10; dma_wdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL rmid_rvalid got=%0b exp=0", dma_rvalid); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rmid_mem_we got=%0b exp=0", mem_we); end
        tick();
        reset = 1'b0;
        idle();
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
        @(negedge clk);
        checks++; if (core_rdata !== model_mem[4]) begin failures++; $display("FAIL rmid_readback got=%h exp=%h", core_rdata, model_mem[4]); end
        checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL rmid_rvalid_after got=%0b exp=0", dma_rvalid); end
        tick();
        idle();
        tick();
    endtask

    // Random traffic against a transaction-level model of the arbitration
    // rules: requests, owner decision, memory effects and read responses.
    task automatic test_random();
        int          lost = 0;
        bit          pend_rv = 1'b0;
        logic [31:0] pend_rd = '0;
        bit          c_stalled = 1'b0, d_pending = 1'b0;
        bit          c_r = 1'b0, c_w = 1'b0, d_w = 1'b0;
        int          c_i = 0, d_i = 0;
        logic [31:0] c_d = '0, d_d = '0;
        bit          dma_wins, core_wins, exp_we;
        logic [31:0] exp_addr, exp_wdata;
        for (int n = 0; n < 400; n++) begin
            if (!c_stalled) begin
                c_r = ($urandom_range(0, 3) != 0);
                c_w = $urandom_range(0, 1) == 1;
                c_i = $urandom_range(0, 63);
                c_d = $urandom;
            end
            if (!d_pending) begin
                d_pending = ($urandom_range(0, 2) != 0);
                d_w = $urandom_range(0, 1) == 1;
                d_i = $urandom_range(0, 63);
                d_d = $urandom;
            end
            core_req = c_r; core_we = c_w; core_addr = 32'(c_i) << 2; core_wdata = c_d;
            dma_req  = d_pending; dma_we = d_w; dma_addr = 32'(d_i) << 2; dma_wdata = d_d;

            dma_wins  = d_pending && (!c_r || lost == SM);
            core_wins = c_r && !dma_wins;
            exp_we    = (dma_wins && d_w) || (core_wins && c_w);
            exp_addr  = dma_wins ? 32'(d_i) << 2 : 32'(c_i) << 2;
            exp_wdata = dma_wins ? d_d : c_d;

            @(negedge clk);
            checks++; if (dma_gnt !== dma_wins) begin failures++; $display("FAIL rnd_gnt n=%0d got=%0b exp=%0b", n, dma_gnt, dma_wins); end
            checks++; if (core_stall !== (dma_wins && c_r)) begin failures++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, core_stall, dma_wins && c_r); end
            checks++; if (mem_we !== exp_we) begin failures++; $display("FAIL rnd_we n=%0d got=%0b exp=%0b", n, mem_we, exp_we); end
            if (dma_wins || core_wins) begin
                checks++; if (mem_addr !== exp_addr) begin failures++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, mem_addr, exp_addr); end
            end
            if (exp_we) begin
                checks++; if (mem_wdata !== exp_wdata) begin failures++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, mem_wdata, exp_wdata); end
            end
            if (core_wins && !c_w) begin
                checks++; if (core_rdata !== model_mem[c_i]) begin failures++; $display("FAIL rnd_core_rdata n=%0d got=%h exp=%h", n, core_rdata, model_mem[c_i]); end
            end
            checks++; if (dma_rvalid !== pend_rv) begin failures++; $display("FAIL rnd_rvalid n=%0d got=%0b exp=%0b", n, dma_rvalid, pend_rv); end
            if (pend_rv) begin
                checks++; if (dma_rdata !== pend_rd) begin failures++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, dma_rdata, pend_rd); end
            end

            pend_rv = dma_wins && !d_w;
            if (pend_rv) pend_rd = model_mem[d_i];
            if (core_wins && c_w) model_mem[c_i] = c_d;
            if (dma_wins && d_w)  model_mem[d_i] = d_d;
            lost      = (d_pending && !dma_wins) ? ((lost < SM) ? lost + 1 : SM) : 0;
            c_stalled = dma_wins && c_r;
            if (dma_wins) d_pending = 1'b0;
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_core_store();
        test_dma_read();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
